// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg -- shared definitions for the 8-point FFT controller slice.
//   N / LOG2N   : transform length and its log2
//   DATA_W      : sample width of the datapath that this controller drives
//   TW_IDX_W    : twiddle ROM index width
//   state_e     : controller FSM states
//   bit_rev()   : LOG2N-bit bit reversal used for the load address order
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int N        = 8;
    localparam int LOG2N    = 3;
    localparam int DATA_W   = 16;
    localparam int TW_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD,
        ST_DONE
    } state_e;

    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// ----------------------------------------------------------------------------
// fft8_addr_gen -- combinational radix-2 butterfly address generator.
// Maps (stage, butterfly index k) to the two RAM legs and the twiddle index:
//   span = 2^stage, pos = k mod span, grp = k div span
//   addr_a = 2*span*grp + pos, addr_b = addr_a + span
//   tw_index = pos * 2^(2-stage)
// Ports:
//   stage    in  2  current stage 0..2
//   k        in  2  butterfly index within the stage 0..3
//   addr_a   out 3  upper-leg address
//   addr_b   out 3  lower-leg address
//   tw_index out 3  twiddle ROM index
// ----------------------------------------------------------------------------
module fft8_addr_gen
    import fft_pkg::*;
(
    input  logic [1:0]          stage,
    input  logic [1:0]          k,
    output logic [LOG2N-1:0]    addr_a,
    output logic [LOG2N-1:0]    addr_b,
    output logic [TW_IDX_W-1:0] tw_index
);

    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;

    // Powers of two make mod/div/multiply plain masks and shifts.
    always_comb begin
        span     = 3'd1 << stage;
        pos      = {1'b0, k} & (span - 3'd1);
        grp      = {1'b0, k} >> stage;
        addr_a   = (grp << (stage + 2'd1)) + pos;
        addr_b   = addr_a + span;
        tw_index = pos << (2'd2 - stage);
    end

endmodule

// File: rtl/fft8_ctrl.sv
// ----------------------------------------------------------------------------
// fft8_ctrl -- sequencing controller for an 8-point in-place radix-2 FFT.
// Loads 8 samples in bit-reversed address order, issues 3 stages of
// 4 butterflies (each stage followed by one drain cycle), writes back one
// cycle after each issue (twiddle ROM latency), then unloads in natural order.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         begin a transform (IDLE only)
//   in_valid / in_ready           sample load handshake
//   ld_addr, ld_we                sample RAM write address / strobe
//   tw_index, tw_en               twiddle ROM index / enable
//   bf_addr_a, bf_addr_b, bf_rd   butterfly read addresses / issue strobe
//   wb_addr_a, wb_addr_b, wb_we   butterfly write-back addresses / strobe
//   stage                         current stage 0..2
//   out_valid / out_ready         result unload handshake
//   out_addr                      result RAM read address
//   busy, done                    not-IDLE flag, one-cycle completion pulse
// ----------------------------------------------------------------------------
module fft8_ctrl
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LOG2N-1:0]    ld_addr,
    output logic                ld_we,
    output logic [TW_IDX_W-1:0] tw_index,
    output logic                tw_en,
    output logic [LOG2N-1:0]    bf_addr_a,
    output logic [LOG2N-1:0]    bf_addr_b,
    output logic                bf_rd,
    output logic [LOG2N-1:0]    wb_addr_a,
    output logic [LOG2N-1:0]    wb_addr_b,
    output logic                wb_we,
    output logic [1:0]          stage,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOG2N-1:0]    out_addr,
    output logic                busy,
    output logic                done
);

    state_e           state_q, state_d;
    logic [LOG2N-1:0] n_q, n_d;          // load counter
    logic [LOG2N-1:0] m_q, m_d;          // unload counter
    logic [1:0]       k_q, k_d;          // butterfly index within stage
    logic [1:0]       stage_q, stage_d;
    logic             drain_q, drain_d;  // current cycle is a stage drain
    logic             wb_we_q, wb_we_d;
    logic [LOG2N-1:0] wb_addr_a_q, wb_addr_a_d;
    logic [LOG2N-1:0] wb_addr_b_q, wb_addr_b_d;

    logic [LOG2N-1:0]    gen_addr_a, gen_addr_b;
    logic [TW_IDX_W-1:0] gen_tw_index;

    fft8_addr_gen u_addr_gen (
        .stage    (stage_q),
        .k        (k_q),
        .addr_a   (gen_addr_a),
        .addr_b   (gen_addr_b),
        .tw_index (gen_tw_index)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        m_d       = m_q;
        k_d       = k_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        in_ready  = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        tw_en     = 1'b0;
        tw_index  = '0;
        bf_rd     = 1'b0;
        bf_addr_a = '0;
        bf_addr_b = '0;
        stage     = '0;
        out_valid = 1'b0;
        out_addr  = '0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                ld_we    = in_valid;
                if (in_valid) begin
                    ld_addr = bit_rev(n_q);
                    if (n_q == 3'(N - 1)) begin
                        n_d     = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        n_d = n_q + 3'd1;
                    end
                end
            end
            ST_COMPUTE: begin
                stage = stage_q;
                if (!drain_q) begin
                    bf_rd     = 1'b1;
                    tw_en     = 1'b1;
                    bf_addr_a = gen_addr_a;
                    bf_addr_b = gen_addr_b;
                    tw_index  = gen_tw_index;
                    if (k_q == 2'd3) begin
                        k_d     = '0;
                        drain_d = 1'b1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    // Stage advances only out of a drain cycle.
                    drain_d = 1'b0;
                    if (stage_q == 2'(LOG2N - 1)) begin
                        stage_d = '0;
                        state_d = ST_UNLOAD;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_addr  = m_q;
                if (out_ready) begin
                    if (m_q == 3'(N - 1)) begin
                        m_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        m_d = m_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Write-back mirrors the issue one cycle later (twiddle ROM latency);
        // the issue-side addresses are already zero when bf_rd is low.
        wb_we_d     = bf_rd;
        wb_addr_a_d = bf_addr_a;
        wb_addr_b_d = bf_addr_b;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            m_q         <= '0;
            k_q         <= '0;
            stage_q     <= '0;
            drain_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_a_q <= '0;
            wb_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            k_q         <= k_d;
            stage_q     <= stage_d;
            drain_q     <= drain_d;
            wb_we_q     <= wb_we_d;
            wb_addr_a_q <= wb_addr_a_d;
            wb_addr_b_q <= wb_addr_b_d;
        end
    end

    assign wb_we     = wb_we_q;
    assign wb_addr_a = wb_addr_a_q;
    assign wb_addr_b = wb_addr_b_q;

endmodule

// File: tb/tb_fft8_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft8_ctrl -- self-checking bench for fft8_ctrl.
// A behavioural model tracks the transform as a phase plus a position
// (samples taken, compute cycle 0..14, results given) and derives every
// expected output arithmetically each cycle.
// ----------------------------------------------------------------------------
module tb_fft8_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       in_ready, ld_we, tw_en, bf_rd, wb_we, out_valid, busy, done;
    logic [2:0] ld_addr, tw_index, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, out_addr;
    logic [1:0] stage;

    fft8_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_addr   (ld_addr),
        .ld_we     (ld_we),
        .tw_index  (tw_index),
        .tw_en     (tw_en),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .bf_rd     (bf_rd),
        .wb_addr_a (wb_addr_a),
        .wb_addr_b (wb_addr_b),
        .wb_we     (wb_we),
        .stage     (stage),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 load, 2 compute, 3 unload, 4 done.
    int m_ph   = 0;
    int m_cnt  = 0;  // samples taken (load) or results given (unload)
    int m_cc   = 0;  // compute cycle 0..14
    int m_prd  = 0;  // previous-cycle issue and addresses, for write-back
    int m_pa   = 0;
    int m_pb   = 0;

    function automatic int rev3(input int v);
        int r = 0;
        for (int i = 0; i < 3; i++) if (((v >> i) & 1) != 0) r |= 1 << (2 - i);
        return r;
    endfunction

    // One clock: drive inputs, check this cycle's outputs, advance the model.
    task automatic step(input logic r, input logic s, input logic iv, input logic orr);
        int e_ld_we, e_ld_addr, e_rd, e_a, e_b, e_tw, e_stg, slot, span;
        @(negedge clk);
        rst = r; start = s; in_valid = iv; out_ready = orr;
        #1;
        e_ld_we = (m_ph == 1 && iv) ? 1 : 0;
        e_ld_addr = e_ld_we ? rev3(m_cnt) : 0;
        e_rd = 0; e_a = 0; e_b = 0; e_tw = 0; e_stg = 0;
        if (m_ph == 2) begin
            e_stg = m_cc / 5;
            slot  = m_cc % 5;
            if (slot < 4) begin
                span = 2 ** e_stg;
                e_rd = 1;
                e_a  = 2 * span * (slot / span) + slot % span;
                e_b  = e_a + span;
                e_tw = (slot % span) * (2 ** (2 - e_stg));
            end
        end
        check("ctl", 32'({busy, done, in_ready, ld_we, out_valid, bf_rd, tw_en, wb_we}),
              32'({m_ph != 0, m_ph == 4, m_ph == 1, e_ld_we == 1, m_ph == 3,
                   e_rd == 1, e_rd == 1, m_prd == 1}));
        check("ld_addr", 32'(ld_addr), 32'(e_ld_addr));
        check("bf", 32'({stage, bf_addr_a, bf_addr_b, tw_index}),
              32'({2'(e_stg), 3'(e_a), 3'(e_b), 3'(e_tw)}));
        check("wb", 32'({wb_addr_a, wb_addr_b}), 32'({3'(m_pa), 3'(m_pb)}));
        check("out_addr", 32'(out_addr), (m_ph == 3) ? 32'(m_cnt) : 32'd0);
        @(posedge clk);
        if (r) begin
            m_ph = 0; m_cnt = 0; m_cc = 0; m_prd = 0; m_pa = 0; m_pb = 0;
        end else begin
            m_prd = e_rd; m_pa = e_a; m_pb = e_b;
            case (m_ph)
                0: if (s) begin m_ph = 1; m_cnt = 0; end
                1: if (iv) begin
                       m_cnt++;
                       if (m_cnt == 8) begin m_ph = 2; m_cc = 0; m_cnt = 0; end
                   end
                2: begin
                       m_cc++;
                       if (m_cc == 15) begin m_ph = 3; m_cnt = 0; end
                   end
                3: if (orr) begin
                       m_cnt++;
                       if (m_cnt == 8) m_ph = 4;
                   end
                default: m_ph = 0;
            endcase
        end
    endtask

    // One transform. iv_mode/or_mode: 0 always high, 1 fixed pattern, 2 random.
    // rst_cc >= 0 resets at that compute cycle; rnd_rst adds rare random resets.
    task automatic run_txn(input int iv_mode, input int or_mode, input int rst_cc, input bit rnd_rst);
        int   ld_i = 0;
        int   ul_i = 0;
        bit   fin  = 0;
        logic [4:0] or_pat = 5'b01101;  // out_ready 1,0,1,1,0 from bit 0
        logic r, iv, orr;
        step(1'b0, 1'b1, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 400; i++) begin
            if (m_ph == 0) begin fin = 1; break; end
            iv  = 1'($urandom);
            orr = 1'($urandom);
            if (m_ph == 1) begin
                iv = (iv_mode == 0) ? 1'b1 : (iv_mode == 1) ? ((ld_i % 3) == 0) : iv;
                ld_i++;
            end
            if (m_ph == 3) begin
                orr = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? or_pat[ul_i % 5] : orr;
                ul_i++;
            end
            r = (rst_cc >= 0 && m_ph == 2 && m_cc == rst_cc) ||
                (rnd_rst && $urandom_range(63) == 0);
            step(r, ($urandom_range(3) == 0), iv, orr);
        end
        if (!fin) check("txn_timeout", 32'(m_ph), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);       // idle after reset
        step(1'b1, 1'b1, 1'b0, 1'b0);       // start and rst together: rst wins
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        run_txn(0, 0, -1, 1'b0);            // streaming load, free unload
        run_txn(1, 1, -1, 1'b0);            // gapped load, stalled unload
        run_txn(0, 0, 7, 1'b0);             // reset at stage 1, k = 2
        step(1'b0, 1'b0, 1'b1, 1'b1);
        run_txn(0, 1, -1, 1'b0);            // restart after reset
        for (int t = 0; t < 20; t++) begin
            run_txn(2, 2, -1, 1'b1);
            if ($urandom_range(1) == 0) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
